// File: rtl/periph_timer_ctrl.sv
// periph_timer_ctrl: bus-programmable timer/divider with tick, divided clock and irq
//
// Build option: define TIMER_PRESCALE_EN to add the 16-bit PSC register at
// BASE+0xC and a prescaler that paces the counter. When it is undefined, 0xC
// reads 0 and writes to it are dropped.
//
// Ports:
//   sys_clk  system clock, all logic on posedge
//   reset    asynchronous active-high reset
//   addr     bus byte address, bits [3:2] select TH/TL/TCON/PSC inside the base window
//   wr_en    write strobe
//   wdata    write data
//   rdata    combinational read of the addressed register, 0 if unmapped
//   tick     one-cycle pulse after each expiry
//   div_out  toggles on every expiry (50% duty divided clock)
//   irq      TCON.flag & TCON.irq_en
module periph_timer_ctrl #(
   parameter int unsigned WIDTH     = 32,
   parameter logic [31:0] ADDR_BASE = 32'h0
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic [31:0]      addr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             tick,
   output logic             div_out,
   output logic             irq
);
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   logic [31:0]      off;
   logic             hit, we_th, we_tl, we_tcon;
   logic             unused_ok;
   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] th_q, th_d, tl_q, tl_d, psc_rd;
   logic             en_q, en_d, irq_en_q, irq_en_d, flag_q, flag_d, oneshot_q, oneshot_d;
   logic             tick_q, div_q;
   logic             pace, advance, expire, stop, oneshot_done;

   // The window is 16 bytes from ADDR_BASE; byte-lane bits are ignored.
   assign off       = addr - ADDR_BASE;
   assign hit       = off[31:4] == '0;
   assign unused_ok = ^off[1:0];
   assign we_th     = wr_en & hit & (off[3:2] == 2'd0);
   assign we_tl     = wr_en & hit & (off[3:2] == 2'd1);
   assign we_tcon   = wr_en & hit & (off[3:2] == 2'd2);

`ifdef TIMER_PRESCALE_EN
   logic        we_psc;
   logic [15:0] psc_q, psc_d, pcnt_q, pcnt_d;
   assign we_psc = wr_en & hit & (off[3:2] == 2'd3);
   assign psc_d  = we_psc ? wdata[15:0] : psc_q;
   // One advance every PSC+1 cycles; the count restarts in IDLE and on PSC writes.
   assign pace   = pcnt_q == psc_q;
   assign pcnt_d = (state_q == S_IDLE || we_psc || pace) ? 16'd0 : pcnt_q + 16'd1;
   assign psc_rd = WIDTH'(psc_q);
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         psc_q  <= '0;
         pcnt_q <= '0;
      end else begin
         psc_q  <= psc_d;
         pcnt_q <= pcnt_d;
      end
   end
`else
   assign pace   = 1'b1;
   assign psc_rd = '0;
`endif

   // Writing en=0 stops the counter on the same edge, so that cycle never advances.
   assign stop         = we_tcon & ~wdata[0];
   assign advance      = (state_q == S_RUN) & ~stop & pace;
   // A CPU write to TL overrides and suppresses an expiry in the same cycle.
   assign expire       = advance & ~we_tl & (tl_q == '1);
   assign oneshot_done = expire & oneshot_q;

   always_comb begin
      th_d      = we_th ? wdata : th_q;
      tl_d      = we_tl ? wdata : expire ? th_q : advance ? tl_q + WIDTH'(1) : tl_q;
      en_d      = (we_tcon ? wdata[0] : en_q) & ~oneshot_done;
      irq_en_d  = we_tcon ? wdata[1] : irq_en_q;
      oneshot_d = (we_tcon ? wdata[3] : oneshot_q) & ~oneshot_done;
      // Hardware set beats a write-1-to-clear in the same cycle.
      flag_d    = expire | (flag_q & ~(we_tcon & wdata[2]));
      state_d   = en_d ? S_RUN : S_IDLE;
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         th_q      <= '0;
         tl_q      <= '0;
         en_q      <= 1'b0;
         irq_en_q  <= 1'b0;
         flag_q    <= 1'b0;
         oneshot_q <= 1'b0;
         tick_q    <= 1'b0;
         div_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         th_q      <= th_d;
         tl_q      <= tl_d;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         flag_q    <= flag_d;
         oneshot_q <= oneshot_d;
         tick_q    <= expire;
         div_q     <= div_q ^ expire;
      end
   end

   always_comb begin
      rdata = !hit               ? '0 :
              off[3:2] == 2'd0   ? th_q :
              off[3:2] == 2'd1   ? tl_q :
              off[3:2] == 2'd2   ? WIDTH'({oneshot_q, flag_q, irq_en_q, en_q}) :
                                   psc_rd;
   end

   assign tick    = tick_q;
   assign div_out = div_q;
   assign irq     = flag_q & irq_en_q;
endmodule

// File: tb/tb_periph_timer_ctrl.sv
// tb_periph_timer_ctrl: directed vectors for periph_timer_ctrl
module tb_periph_timer_ctrl;
   logic        sys_clk = 1'b0;
   logic        reset, wr_en, tick, div_out, irq;
   logic [31:0] addr, wdata, rdata, v;
   int          n_vec = 0;
   int          n_err = 0;
   int          per;

   periph_timer_ctrl #(.WIDTH(32), .ADDR_BASE(32'h0)) dut (
      .sys_clk(sys_clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
      .rdata(rdata), .tick(tick), .div_out(div_out), .irq(irq)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a;
      wdata = d;
      wr_en = 1'b1;
      @(negedge sys_clk);
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   initial begin
      reset = 1'b1;
      wr_en = 1'b0;
      addr  = '0;
      wdata = '0;
      repeat (2) @(negedge sys_clk);
      reset = 1'b0;
      chk("rst_tick", {31'd0, tick}, 0);
      chk("rst_div", {31'd0, div_out}, 0);
      chk("rst_irq", {31'd0, irq}, 0);
      rd(32'h8, v); chk("rst_tcon", v, 0);
      // 1: free-running period 4
      wr(32'h0, 32'hFFFF_FFFC);
      wr(32'h4, 32'hFFFF_FFFC);
      wr(32'h8, 32'h3);
      for (int i = 1; i <= 12; i++) begin
         @(negedge sys_clk);
         chk($sformatf("t1_tick%0d", i), {31'd0, tick}, {31'd0, i % 4 == 0});
         chk($sformatf("t1_div%0d", i), {31'd0, div_out}, {31'd0, (i / 4) % 2 == 1});
         chk($sformatf("t1_irq%0d", i), {31'd0, irq}, {31'd0, i >= 4});
      end
      wr(32'h8, 32'h7);
      chk("t1_irq_clr", {31'd0, irq}, 0);
      rd(32'h8, v); chk("t1_tcon_clr", v, 32'h3);
      repeat (2) @(negedge sys_clk);
      chk("t1_irq_hold", {31'd0, irq}, 0);
      @(negedge sys_clk);
      chk("t1_irq_set", {31'd0, irq}, 1);
      chk("t1_tick_set", {31'd0, tick}, 1);
      wr(32'h8, 32'h4);
      // 2: oneshot
      wr(32'h0, 32'h0);
      wr(32'h4, 32'hFFFF_FFFE);
      wr(32'h8, 32'h9);
      @(negedge sys_clk);
      chk("t2_tick_early", {31'd0, tick}, 0);
      @(negedge sys_clk);
      chk("t2_tick", {31'd0, tick}, 1);
      rd(32'h8, v); chk("t2_tcon", v, 32'h4);
      rd(32'h4, v); chk("t2_tl", v, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         chk($sformatf("t2_quiet%0d", i), {31'd0, tick}, 0);
      end
      rd(32'h4, v); chk("t2_tl_hold", v, 0);
      // 3: TL write on the expiry cycle
      wr(32'h8, 32'h4);
      wr(32'h0, 32'hFFFF_FFF0);
      wr(32'h4, 32'hFFFF_FFFE);
      wr(32'h8, 32'h1);
      @(negedge sys_clk);
      rd(32'h4, v); chk("t3_tl_ff", v, 32'hFFFF_FFFF);
      wr(32'h4, 32'h1234);
      chk("t3_tick", {31'd0, tick}, 0);
      rd(32'h8, v); chk("t3_tcon", v, 32'h1);
      rd(32'h4, v); chk("t3_tl", v, 32'h1234);
      @(negedge sys_clk);
      rd(32'h4, v); chk("t3_tl_inc", v, 32'h1235);
      // 4: expiry and flag clear collide
      wr(32'h4, 32'hFFFF_FFFE);
      @(negedge sys_clk);
      wr(32'h8, 32'h7);
      chk("t4_tick", {31'd0, tick}, 1);
      rd(32'h8, v); chk("t4_tcon", v, 32'h7);
      chk("t4_irq", {31'd0, irq}, 1);
      // 5: reset mid-run
      wr(32'h4, 32'hFFFF_FFF0);
      @(negedge sys_clk);
      reset = 1'b1;
      rd(32'h4, v); chk("t5_tl", v, 0);
      rd(32'h0, v); chk("t5_th", v, 0);
      rd(32'h8, v); chk("t5_tcon", v, 0);
      chk("t5_tick", {31'd0, tick}, 0);
      chk("t5_div", {31'd0, div_out}, 0);
      chk("t5_irq", {31'd0, irq}, 0);
      @(negedge sys_clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         chk($sformatf("t5_quiet%0d", i), {31'd0, tick}, 0);
      end
      rd(32'h4, v); chk("t5_tl_idle", v, 0);
      wr(32'h10, 32'hDEAD);
      rd(32'h0, v); chk("oob_th", v, 0);
      rd(32'h10, v); chk("oob_rd", v, 0);
      // 6: prescaler
`ifdef TIMER_PRESCALE_EN
      per = 8;
`else
      per = 2;
`endif
      wr(32'h0, 32'hFFFF_FFFE);
      wr(32'h4, 32'hFFFF_FFFE);
      wr(32'hC, 32'h3);
      wr(32'h8, 32'h1);
      for (int i = 1; i <= 16; i++) begin
         @(negedge sys_clk);
         chk($sformatf("t6_tick%0d", i), {31'd0, tick}, {31'd0, i % per == 0});
      end
      rd(32'hC, v);
`ifdef TIMER_PRESCALE_EN
      chk("t6_psc", v, 32'h3);
`else
      chk("t6_psc", v, 32'h0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
